// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Bundles the result-side signals of the CDB arbiter: the per-unit result
//   handshake from ALU/BRU/LSU and the registered common data bus broadcast.
//
//   Ports (signals):
//     fu_valid  [NUM_FU]             unit -> arbiter, result valid
//     fu_ready  [NUM_FU]             arbiter -> unit, buffer can accept
//     fu_wen    [NUM_FU]             result writes a physical register
//     fu_phy_rd [NUM_FU*PHY_WIDTH]   destination preg, unit i in slice i
//     fu_rob_id [NUM_FU*ROB_WIDTH]   ROB index, same packing
//     fu_data   [NUM_FU*DATA_WIDTH]  result value, same packing
//     cdb_valid/cdb_wen/cdb_phy_rd/cdb_rob_id/cdb_data/cdb_src
//                                    registered broadcast (cdb_src = debug)
//
//   Handshake: a result transfers from unit i on a rising edge where
//   fu_valid[i] and fu_ready[i] are both high. fu_ready does not depend on
//   fu_valid. The broadcast has no backpressure: cdb_valid is high for exactly
//   one cycle per result and the other cdb_* fields are meaningful only then.
//
//   Modports: slave = arbiter side, master = execution-unit / consumer side.

interface cdb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PHY_WIDTH  = 6,
    parameter int ROB_WIDTH  = 5,
    parameter int NUM_FU     = 3
);
    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU-1:0]            fu_ready;
    logic [NUM_FU-1:0]            fu_wen;
    logic [NUM_FU*PHY_WIDTH-1:0]  fu_phy_rd;
    logic [NUM_FU*ROB_WIDTH-1:0]  fu_rob_id;
    logic [NUM_FU*DATA_WIDTH-1:0] fu_data;

    logic                         cdb_valid;
    logic                         cdb_wen;
    logic [PHY_WIDTH-1:0]         cdb_phy_rd;
    logic [ROB_WIDTH-1:0]         cdb_rob_id;
    logic [DATA_WIDTH-1:0]        cdb_data;
    logic [1:0]                   cdb_src;

    modport slave (
        input  fu_valid, fu_wen, fu_phy_rd, fu_rob_id, fu_data,
        output fu_ready,
        output cdb_valid, cdb_wen, cdb_phy_rd, cdb_rob_id, cdb_data, cdb_src
    );

    modport master (
        output fu_valid, fu_wen, fu_phy_rd, fu_rob_id, fu_data,
        input  fu_ready,
        input  cdb_valid, cdb_wen, cdb_phy_rd, cdb_rob_id, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Collects completed results from ALU (0), BRU (1) and LSU (2) into a
//   2-entry FIFO per unit and serialises them onto the single common data
//   bus, one registered broadcast per cycle, using a round-robin arbiter.
//
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous active-low reset (0 = in reset)
//     flush  synchronous pipeline flush: empties all buffers, drops the
//            handshakes and any grant of the flush cycle
//     bus    cdb_arbiter_if.slave: per-unit result handshake in, CDB out

module cdb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int PHY_WIDTH  = 6,
    parameter int ROB_WIDTH  = 5,
    parameter int NUM_FU     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int ENTRY_W = 1 + PHY_WIDTH + ROB_WIDTH + DATA_WIDTH;
    typedef logic [ENTRY_W-1:0] entry_t;

    // Result buffers: storage carries no reset, validity lives in count_q.
    entry_t                 mem_q [NUM_FU][2];
    logic [NUM_FU-1:0]      wr_ptr_q, wr_ptr_d;
    logic [NUM_FU-1:0]      rd_ptr_q, rd_ptr_d;
    logic [NUM_FU-1:0][1:0] count_q, count_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;

    logic                   cdb_valid_q, cdb_valid_d;
    logic                   cdb_wen_q, cdb_wen_d;
    logic [PHY_WIDTH-1:0]   cdb_phy_rd_q, cdb_phy_rd_d;
    logic [ROB_WIDTH-1:0]   cdb_rob_id_q, cdb_rob_id_d;
    logic [DATA_WIDTH-1:0]  cdb_data_q, cdb_data_d;
    logic [1:0]             cdb_src_q, cdb_src_d;

    logic [NUM_FU-1:0]      ready;
    logic [NUM_FU-1:0]      not_empty;
    logic [NUM_FU-1:0]      push;
    logic [NUM_FU-1:0]      pop;
    entry_t                 wr_entry [NUM_FU];
    logic                   grant_valid;
    logic [1:0]             grant_idx;
    logic [2:0]             cand;
    entry_t                 head;

    // Ready is taken from the registered count only, so a full buffer stays
    // not-ready even in a cycle where it is being popped.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            ready[i]     = rst & (count_q[i] != 2'd2);
            not_empty[i] = (count_q[i] != 2'd0);
            push[i]      = bus.fu_valid[i] & ready[i] & ~flush;
            wr_entry[i]  = {bus.fu_wen[i],
                            bus.fu_phy_rd[i*PHY_WIDTH +: PHY_WIDTH],
                            bus.fu_rob_id[i*ROB_WIDTH +: ROB_WIDTH],
                            bus.fu_data[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    assign bus.fu_ready = ready;

    // Round-robin search: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 3'd0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!grant_valid && not_empty[cand[1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i] = grant_valid & (grant_idx == 2'(i)) & ~flush;
        end
    end

    assign head = mem_q[grant_idx][rd_ptr_q[grant_idx]];

    // Next-state: buffer bookkeeping, round-robin pointer, broadcast register.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            count_d[i]  = count_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (flush) begin
                count_d[i]  = 2'd0;
                wr_ptr_d[i] = 1'b0;
                rd_ptr_d[i] = 1'b0;
            end else begin
                if (push[i]) begin
                    wr_ptr_d[i] = ~wr_ptr_q[i];
                end
                if (pop[i]) begin
                    rd_ptr_d[i] = ~rd_ptr_q[i];
                end
                case ({push[i], pop[i]})
                    2'b10:   count_d[i] = count_q[i] + 2'd1;
                    2'b01:   count_d[i] = count_q[i] - 2'd1;
                    default: count_d[i] = count_q[i];
                endcase
            end
        end

        rr_ptr_d     = rr_ptr_q;
        cdb_valid_d  = 1'b0;
        cdb_wen_d    = cdb_wen_q;
        cdb_phy_rd_d = cdb_phy_rd_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_data_d   = cdb_data_q;
        cdb_src_d    = cdb_src_q;

        if (flush) begin
            rr_ptr_d = 2'd0;
        end else if (grant_valid) begin
            rr_ptr_d    = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            cdb_valid_d = 1'b1;
            {cdb_wen_d, cdb_phy_rd_d, cdb_rob_id_d, cdb_data_d} = head;
            cdb_src_d   = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= wr_entry[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rr_ptr_q     <= 2'd0;
            cdb_valid_q  <= 1'b0;
            cdb_wen_q    <= 1'b0;
            cdb_phy_rd_q <= '0;
            cdb_rob_id_q <= '0;
            cdb_data_q   <= '0;
            cdb_src_q    <= 2'd0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_wen_q    <= cdb_wen_d;
            cdb_phy_rd_q <= cdb_phy_rd_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_wen    = cdb_wen_q;
    assign bus.cdb_phy_rd = cdb_phy_rd_q;
    assign bus.cdb_rob_id = cdb_rob_id_q;
    assign bus.cdb_data   = cdb_data_q;
    assign bus.cdb_src    = cdb_src_q;
endmodule
